// File: rtl/eth_fifo_tx_reader.sv
// eth_fifo_tx_reader
//   Drain side of eth_fifo. Pops DATA_WIDTH-bit words from the FIFO and
//   serialises them into a byte stream, least-significant byte first. A frame
//   of frame_len bytes is requested with a start pulse. tx_last marks the
//   final byte. Sits between eth_fifo and the byte-wide MAC transmit path.
//
// Ports
//   clk        : clock; all logic runs on the rising edge
//   reset      : asynchronous, active-low reset
//   start      : frame request pulse; sampled only in IDLE
//   frame_len  : frame length in bytes; latched together with start
//   abort      : synchronous abort of the current frame; has priority over start
//   fifo_data  : head word of eth_fifo; valid while fifo_empty=0
//   fifo_empty : eth_fifo empty flag
//   fifo_read  : one-cycle pop strobe to eth_fifo
//   tx_data    : output byte
//   tx_valid   : tx_data is valid
//   tx_ready   : sink accepts the byte when tx_valid & tx_ready
//   tx_last    : qualifies the final byte of the frame
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse after the last byte is accepted
//   underrun   : one-cycle pulse when the frame is dropped because the FIFO
//                stayed empty for too long
//   fsm_state  : current FSM state (0=IDLE, 1=FETCH, 2=SEND), for observation
//
// Handshake: a byte transfers on a rising edge where tx_valid and tx_ready are
// both high. While tx_valid is high and tx_ready is low, tx_data and tx_last
// stay unchanged. tx_valid never drops without a transfer, except on abort or
// reset.

module eth_fifo_tx_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun,
  output logic [1:0]            fsm_state
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] shift;
  logic [IDX_W-1:0]      byte_idx;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  done_q;
  logic                  underrun_q;

  // The pop strobe has to be combinational. The word must be consumed in the
  // same cycle it is loaded, which gives the 2-cycle start-to-valid latency.
  // Abort suppresses the pop so that no word is lost from the FIFO.
  assign fifo_read = (state == FETCH) && !fifo_empty && !abort;

  assign tx_valid  = (state == SEND);
  assign tx_data   = shift[7:0];
  assign tx_last   = (state == SEND) && (remaining == LEN_WIDTH'(1));
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign underrun  = underrun_q;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      remaining  <= '0;
      shift      <= '0;
      byte_idx   <= '0;
      wait_cnt   <= '0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        wait_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              remaining <= frame_len;
              byte_idx  <= '0;
              wait_cnt  <= '0;
              if (frame_len == '0) begin
                done_q <= 1'b1;
              end else begin
                state <= FETCH;
              end
            end
          end

          FETCH: begin
            if (!fifo_empty) begin
              shift    <= fifo_data;
              byte_idx <= '0;
              wait_cnt <= '0;
              state    <= SEND;
            end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
              // This is the TIMEOUT-th consecutive empty cycle.
              underrun_q <= 1'b1;
              wait_cnt   <= '0;
              state      <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end

          SEND: begin
            if (tx_ready) begin
              remaining <= remaining - LEN_WIDTH'(1);
              shift     <= shift >> 8;
              byte_idx  <= byte_idx + IDX_W'(1);
              if (remaining == LEN_WIDTH'(1)) begin
                // The rest of the current word is discarded.
                done_q <= 1'b1;
                state  <= IDLE;
              end else if (byte_idx == IDX_W'(BYTES - 1)) begin
                state <= FETCH;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_fifo_tx_reader.sv
// tb_eth_fifo_tx_reader
//   Directed bench for eth_fifo_tx_reader (DATA_WIDTH=32, TIMEOUT=16).
//   It has a small FIFO model feeding the DUT and a negedge monitor that
//   collects accepted bytes and counts pop, done, underrun and valid cycles.
//   Stimulus consists of a vector table of whole frames plus hand-written
//   sequences for latency, stall, underrun, zero length, reset and abort.

module tb_eth_fifo_tx_reader;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic [LW-1:0] frame_len;
  logic          abort;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_read;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_last;
  logic          busy;
  logic          done;
  logic          underrun;
  logic [1:0]    fsm_state;

  eth_fifo_tx_reader #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .frame_len (frame_len),
    .abort     (abort),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_read (fifo_read),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_last   (tx_last),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun),
    .fsm_state (fsm_state)
  );

  // ---------------- FIFO model ----------------
  logic [DW-1:0] mem [0:63];
  logic [5:0]    wr_ptr = '0;
  logic [5:0]    rd_ptr = '0;
  logic          flush_req = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr];

  always @(posedge clk) begin
    if (flush_req) rd_ptr <= wr_ptr;
    else if (fifo_read) rd_ptr <= rd_ptr + 6'd1;
  end

  // ---------------- monitor ----------------
  logic [8:0] act_q[$];
  int rd_cnt    = 0;
  int done_cnt  = 0;
  int und_cnt   = 0;
  int valid_cnt = 0;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) act_q.push_back({tx_last, tx_data});
    if (fifo_read) rd_cnt++;
    if (done) done_cnt++;
    if (underrun) und_cnt++;
    if (tx_valid) valid_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic flush;
    flush_req = 1'b1;
    tick;
    flush_req = 1'b0;
  endtask

  task automatic expect_frame(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, bytes[8*i +: 8]});
  endtask

  task automatic compare_frame(input string tag, input int base);
    int n_act;
    logic [8:0] e;
    n_act = act_q.size() - base;
    check({tag, "_nbytes"}, n_act, exp_q.size());
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      if (k < n_act) check($sformatf("%s_byte%0d", tag, k), act_q[base + k], e);
    end
  endtask

  // Runs until done, lowering tx_ready for stall_len cycles once stall_at
  // bytes of this frame have been accepted (stall_at < 0: never stall).
  task automatic wait_done(input int stall_at, input int stall_len, input int base,
                           output bit ok);
    int stalled;
    stalled = 0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if ((act_q.size() - base) == stall_at && stalled < stall_len) begin
        tx_ready = 1'b0;
        stalled++;
      end else begin
        tx_ready = 1'b1;
      end
      tick;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    tx_ready = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    int            nw;
    logic [LW-1:0] len;
    int            stall_at;
    int            stall_len;
    logic [63:0]   exp_bytes;
    int            exp_n;
    int            exp_reads;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int base, r0, d0, u0, v0;
    string tag;

    vecs[0] = '{32'h44332211, 32'h0,        1, 16'd4, -1, 0, 64'h0000_0000_4433_2211, 4, 1};
    vecs[1] = '{32'h44332211, 32'h88776655, 2, 16'd6, -1, 0, 64'h0000_6655_4433_2211, 6, 2};
    vecs[2] = '{32'h44332211, 32'h0,        1, 16'd4,  1, 3, 64'h0000_0000_4433_2211, 4, 1};
    vecs[3] = '{32'hDDCCBBAA, 32'h99887755, 2, 16'd5, -1, 0, 64'h0000_0055_DDCC_BBAA, 5, 2};
    vecs[4] = '{32'h04030201, 32'h08070605, 2, 16'd8,  4, 2, 64'h0807_0605_0403_0201, 8, 2};
    vecs[5] = '{32'h000000EE, 32'h0,        1, 16'd1,  0, 2, 64'h0000_0000_0000_00EE, 1, 1};

    reset = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1; frame_len = '0;

    // ---- reset state ----
    tick; tick; tick;
    check("rst_busy",     busy,      0);
    check("rst_tx_valid", tx_valid,  0);
    check("rst_tx_data",  tx_data,   0);
    check("rst_tx_last",  tx_last,   0);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_done",     done,      0);
    check("rst_underrun", underrun,  0);
    check("rst_state",    fsm_state, 0);
    reset = 1'b1;
    tick;

    // ---- table-driven frames ----
    for (int v = 0; v < 6; v++) begin
      flush;
      base = act_q.size(); r0 = rd_cnt; d0 = done_cnt; u0 = und_cnt;
      push(vecs[v].w0);
      if (vecs[v].nw > 1) push(vecs[v].w1);
      expect_frame(vecs[v].exp_bytes, vecs[v].exp_n);
      start = 1'b1; frame_len = vecs[v].len;
      tick;
      start = 1'b0;
      wait_done(vecs[v].stall_at, vecs[v].stall_len, base, ok);
      tag = $sformatf("v%0d", v);
      check({tag, "_done_seen"}, ok, 1);
      tick;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_busy_idle"}, busy, 0);
      check({tag, "_reads"}, rd_cnt - r0, vecs[v].exp_reads);
      check({tag, "_done_cnt"}, done_cnt - d0, 1);
      check({tag, "_underrun_cnt"}, und_cnt - u0, 0);
      check({tag, "_fifo_left"}, 6'(wr_ptr - rd_ptr), vecs[v].nw - vecs[v].exp_reads);
      compare_frame(tag, base);
    end

    // ---- latency and stall hold on byte 0x22 ----
    flush;
    base = act_q.size();
    push(32'h44332211);
    expect_frame(64'h44332211, 4);
    start = 1'b1; frame_len = 16'd4;
    tick;
    start = 1'b0;
    check("lat_fetch_read",  fifo_read, 1);
    check("lat_fetch_valid", tx_valid,  0);
    check("lat_fetch_busy",  busy,      1);
    tick;
    check("lat_first_valid", tx_valid, 1);
    check("lat_first_data",  tx_data,  8'h11);
    check("lat_first_last",  tx_last,  0);
    check("lat_read_once",   fifo_read, 0);
    tick;
    check("stall_pre_data", tx_data, 8'h22);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("stall_hold_valid%0d", i), tx_valid, 1);
      check($sformatf("stall_hold_data%0d", i),  tx_data,  8'h22);
      check($sformatf("stall_hold_last%0d", i),  tx_last,  0);
    end
    wait_done(-1, 0, base, ok);
    check("stall_done_seen", ok, 1);
    tick;
    compare_frame("stall", base);

    // ---- underrun: FIFO empty for TIMEOUT cycles ----
    flush;
    r0 = rd_cnt; u0 = und_cnt; v0 = valid_cnt; d0 = done_cnt;
    start = 1'b1; frame_len = 16'd4;
    tick;
    start = 1'b0;
    ok = 1'b1;
    for (int i = 1; i < TO; i++) begin
      tick;
      if (underrun !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    check("und_no_early", ok, 1);
    tick;
    check("und_pulse", underrun, 1);
    check("und_busy",  busy,     0);
    tick;
    check("und_pulse_end", underrun, 0);
    check("und_reads",     rd_cnt - r0,    0);
    check("und_valid",     valid_cnt - v0, 0);
    check("und_count",     und_cnt - u0,   1);
    check("und_no_done",   done_cnt - d0,  0);

    // ---- empty for 5 cycles, then data arrives ----
    base = act_q.size(); r0 = rd_cnt; u0 = und_cnt;
    expect_frame(64'h44332211, 4);
    start = 1'b1; frame_len = 16'd4;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    check("late_waiting", busy, 1);
    push(32'h44332211);
    wait_done(-1, 0, base, ok);
    check("late_done_seen", ok, 1);
    tick;
    check("late_underrun", und_cnt - u0, 0);
    check("late_reads",    rd_cnt - r0,  1);
    compare_frame("late", base);

    // ---- zero length ----
    flush;
    r0 = rd_cnt; v0 = valid_cnt;
    start = 1'b1; frame_len = 16'd0;
    tick;
    start = 1'b0;
    check("zero_done",  done,      1);
    check("zero_busy",  busy,      0);
    check("zero_read",  fifo_read, 0);
    tick;
    check("zero_done_end", done, 0);
    check("zero_reads",    rd_cnt - r0,    0);
    check("zero_valid",    valid_cnt - v0, 0);

    // ---- start while busy is ignored ----
    flush;
    base = act_q.size(); r0 = rd_cnt;
    push(32'h44332211);
    push(32'h88776655);
    expect_frame(64'h44332211, 4);
    start = 1'b1; frame_len = 16'd4;
    tick;
    frame_len = 16'd8;
    tick;
    start = 1'b0;
    wait_done(-1, 0, base, ok);
    check("busy_start_done_seen", ok, 1);
    tick;
    check("busy_start_reads", rd_cnt - r0, 1);
    compare_frame("busy_start", base);
    tick; tick;
    check("busy_start_idle", busy, 0);

    // ---- asynchronous reset mid-SEND ----
    flush;
    push(32'h44332211);
    start = 1'b1; frame_len = 16'd4;
    tick;
    start = 1'b0;
    tick;
    check("mid_rst_in_send", tx_valid, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", tx_valid,  0);
    check("mid_rst_busy",  busy,      0);
    check("mid_rst_data",  tx_data,   0);
    check("mid_rst_last",  tx_last,   0);
    check("mid_rst_read",  fifo_read, 0);
    check("mid_rst_done",  done,      0);
    tick;
    reset = 1'b1;
    tick;

    // ---- abort mid-frame ----
    flush;
    d0 = done_cnt;
    push(32'h44332211);
    push(32'h88776655);
    start = 1'b1; frame_len = 16'd8;
    tick;
    start = 1'b0;
    tick;
    tick;
    check("abort_pre_data", tx_data, 8'h22);
    tx_ready = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0; tx_ready = 1'b1;
    check("abort_busy",  busy,     0);
    check("abort_valid", tx_valid, 0);
    check("abort_done",  done,     0);
    tick; tick;
    check("abort_no_done", done_cnt - d0, 0);

    // ---- abort in FETCH suppresses the pop ----
    flush;
    r0 = rd_cnt;
    push(32'h44332211);
    start = 1'b1; frame_len = 16'd4;
    tick;
    start = 1'b0;
    check("fabort_read_before", fifo_read, 1);
    abort = 1'b1;
    #1;
    check("fabort_read_gated", fifo_read, 0);
    tick;
    abort = 1'b0;
    check("fabort_idle", busy, 0);
    tick;
    check("fabort_reads", rd_cnt - r0, 0);

    // ---- fresh frame after abort ----
    flush;
    base = act_q.size(); r0 = rd_cnt; d0 = done_cnt;
    push(32'hCAFEF00D);
    expect_frame(64'hCAFEF00D, 4);
    start = 1'b1; frame_len = 16'd4;
    tick;
    start = 1'b0;
    wait_done(-1, 0, base, ok);
    check("fresh_done_seen", ok, 1);
    tick;
    check("fresh_reads", rd_cnt - r0,   1);
    check("fresh_done",  done_cnt - d0, 1);
    compare_frame("fresh", base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
